// File: rtl/rstseq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states and the
// bit positions of the one-hot reset-cause register.
package rstseq_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    RELEASE,
    RUN
  } state_e;

  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_BTN  = 1;
  localparam int CAUSE_LOCK = 2;
  localparam int CAUSE_REQ0 = 3;

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-side bundle of the reset sequencer: raw reset sources in, staged
// resets, ready/LED and last-reset cause out.
interface reset_sequencer_if #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_STAGES = 3
);
  logic                  i_pll_locked;
  logic                  i_button_n;
  logic [NUM_REQ-1:0]    i_req;
  logic [NUM_REQ-1:0]    i_req_en;
  logic [NUM_STAGES-1:0] o_rst;
  logic                  o_ready;
  logic                  o_led;
  logic [NUM_REQ+2:0]    o_cause;

  modport master (
    output i_pll_locked, i_button_n, i_req, i_req_en,
    input  o_rst, o_ready, o_led, o_cause
  );

  modport slave (
    input  i_pll_locked, i_button_n, i_req, i_req_en,
    output o_rst, o_ready, o_led, o_cause
  );
endinterface

// File: rtl/reset_sequencer_sync_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output level
// follows the synchronised input only after it has held for CYCLES cycles.
module sync_debounce #(
  parameter int   CYCLES = 16,
  parameter logic IDLE   = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level
);
  localparam int            CW       = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser starts at the idle level so reset does not look like a press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q    <= IDLE;
      s2_q    <= IDLE;
      level_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      s1_q    <= i_async;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = s2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  assign o_level = level_q;
endmodule

// File: rtl/reset_sequencer.sv
// Combines POR, debounced button, filtered PLL lock and soft requests, then
// releases NUM_STAGES resets in order with a gap, recording the last cause.
module reset_sequencer #(
  parameter int NUM_REQ         = 2,
  parameter int NUM_STAGES      = 3,
  parameter int HOLD_CYCLES     = 4,
  parameter int STAGE_GAP       = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCK_FILTER     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  reset_sequencer_if.slave   bus
);
  import rstseq_pkg::*;

  localparam int CW = NUM_REQ + 3;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int LW = $clog2(LOCK_FILTER + 1);
  localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(STAGE_GAP - 1);
  localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_FILTER);
  localparam logic [KW-1:0] K_LAST     = KW'(NUM_STAGES - 1);

  state_e                state_q, state_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [KW-1:0]         k_q, k_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  ready_q, ready_d;
  logic [CW-1:0]         cause_q, cause_d;

  logic                  lock_s1_q, lock_s2_q;
  logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
  logic                  lock_good, btn_level, btn_trig, trigger;
  logic [NUM_REQ-1:0]    req_hit;

  // Lowest-index request wins when several fire together.
  function automatic logic [CW-1:0] pick_cause(input logic lock_loss, input logic btn,
                                               input logic [NUM_REQ-1:0] reqs);
    logic [CW-1:0] c;
    c = '0;
    if (lock_loss)  c[CAUSE_LOCK] = 1'b1;
    else if (btn)   c[CAUSE_BTN]  = 1'b1;
    else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (reqs[i]) begin
          c                 = '0;
          c[CAUSE_REQ0 + i] = 1'b1;
        end
      end
    end
    return c;
  endfunction

  sync_debounce #(.CYCLES(DEBOUNCE_CYCLES), .IDLE(1'b1)) u_btn (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (bus.i_button_n),
    .o_level (btn_level)
  );

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!lock_s2_q)                  lock_cnt_d = '0;
    else if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
  end

  assign lock_good = (lock_cnt_q == LOCK_MAX);
  assign btn_trig  = ~btn_level;
  assign req_hit   = bus.i_req & bus.i_req_en;
  assign trigger   = btn_trig | ~lock_good | (|req_hit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_s1_q  <= 1'b0;
      lock_s2_q  <= 1'b0;
      lock_cnt_q <= '0;
      state_q    <= ASSERT;
      hold_q     <= HOLD_MAX;
      gap_q      <= '0;
      k_q        <= '0;
      rst_q      <= '1;
      ready_q    <= 1'b0;
      cause_q    <= CW'(1) << CAUSE_POR;
    end else begin
      lock_s1_q  <= bus.i_pll_locked;
      lock_s2_q  <= lock_s1_q;
      lock_cnt_q <= lock_cnt_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      k_q        <= k_d;
      rst_q      <= rst_d;
      ready_q    <= ready_d;
      cause_q    <= cause_d;
    end
  end

  // A trigger from any state abandons whatever release was in progress.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    k_d     = k_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;
    if (trigger) begin
      state_d = ASSERT;
      hold_d  = HOLD_MAX;
      rst_d   = '1;
      ready_d = 1'b0;
      if (state_q != ASSERT) cause_d = pick_cause(~lock_good, btn_trig, req_hit);
    end else begin
      case (state_q)
        ASSERT: begin
          rst_d   = '1;
          ready_d = 1'b0;
          if (hold_q == '0) begin
            state_d = RELEASE;
            k_d     = '0;
            gap_d   = '0;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        RELEASE: begin
          if (gap_q == '0) begin
            rst_d[k_q] = 1'b0;
            gap_d      = GAP_RELOAD;
            if (k_q == K_LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              k_d = k_q + 1'b1;
            end
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
        RUN: begin
          rst_d   = '0;
          ready_d = 1'b1;
        end
        default: state_d = ASSERT;
      endcase
    end
  end

  assign bus.o_rst   = rst_q;
  assign bus.o_ready = ready_q;
  assign bus.o_led   = ready_q;
  assign bus.o_cause = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scenario bench for reset_sequencer: expected output sequences are queued
// when stimulus is applied and compared cycle by cycle as the DUT responds.
module tb_reset_sequencer;
  localparam int NR   = 2;
  localparam int NS   = 3;
  localparam int HOLD = 4;
  localparam int GAP  = 2;

  typedef struct {
    int              cyc;
    logic [NS-1:0]   rst;
    logic            rdy;
    logic [NR+2:0]   cause;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  reset_sequencer_if #(.NUM_REQ(NR), .NUM_STAGES(NS)) bus ();

  reset_sequencer #(
    .NUM_REQ(NR), .NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP),
    .DEBOUNCE_CYCLES(16), .LOCK_FILTER(8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Outputs after edge n are sampled at the negedge where cyc == n.
  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Expected outputs for cycles from..to when trigger was first low at edge t.
  function automatic void push_seq(input int from, input int to, input int t,
                                   input logic [NR+2:0] cause);
    exp_t e;
    for (int c = from; c <= to; c++) begin
      e.cyc   = c;
      e.cause = cause;
      for (int k = 0; k < NS; k++) e.rst[k] = (c < t + HOLD + 1 + k * GAP);
      e.rdy = (c >= t + HOLD + 1 + (NS - 1) * GAP);
      sb.push_back(e);
    end
  endfunction

  task automatic test_reset();
    exp_t e;
    int   r;
    wait_to(3);
    n_chk++;
    if ({bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause} !== {3'b111, 1'b0, 1'b0, 5'b00001}) begin
      n_fail++;
      $display("FAIL reset_values: got rst=%b rdy=%b led=%b cause=%b, want 111/0/0/00001",
               bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause);
    end
    r = cyc;
    rst_n = 1'b1;
    push_seq(r + 1, r + 22, r + 11, 5'b00001);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_to(e.cyc);
      n_chk++;
      if ({bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause} !== {e.rst, e.rdy, e.rdy, e.cause}) begin
        n_fail++;
        $display("FAIL por_sequence cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e.cyc,
                 bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause, e.rst, e.rdy, e.rdy, e.cause);
      end
    end
  endtask

  task automatic test_req_pulse(input string name, input logic [NR-1:0] req,
                                input logic [NR-1:0] en, input logic fires,
                                input logic [NR+2:0] cause);
    exp_t e;
    int   p;
    bus.i_req_en = en;
    p = cyc + 2;
    wait_to(p - 1);
    bus.i_req = req;
    if (fires) push_seq(p, p + 12, p + 1, cause);
    else       push_seq(p, p + 12, -100, cause);
    fork
      begin
        wait_to(p);
        bus.i_req = '0;
      end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        wait_to(e.cyc);
        n_chk++;
        if ({bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause} !== {e.rst, e.rdy, e.rdy, e.cause}) begin
          n_fail++;
          $display("FAIL %s cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", name, e.cyc,
                   bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause, e.rst, e.rdy, e.rdy, e.cause);
        end
      end
    join
    bus.i_req_en = '1;
  endtask

  task automatic test_button_bounce();
    exp_t e;
    int   s;
    s = cyc;
    push_seq(s + 1, s + 90, -100, 5'b10000);
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          wait_to(s + 5 * i);
          bus.i_button_n = ~bus.i_button_n;
        end
        wait_to(s + 60);
        bus.i_button_n = 1'b1;
      end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        wait_to(e.cyc);
        n_chk++;
        if ({bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause} !== {e.rst, e.rdy, e.rdy, e.cause}) begin
          n_fail++;
          $display("FAIL button_bounce cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e.cyc,
                   bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause, e.rst, e.rdy, e.rdy, e.cause);
        end
      end
    join
  endtask

  task automatic test_button_hold();
    exp_t e;
    int   b;
    b = cyc + 1;
    wait_to(b - 1);
    bus.i_button_n = 1'b0;
    // 2 sync + 16 debounce cycles before the reset; release mirrors that on the way up.
    push_seq(b + 1, b + 17, -100, 5'b10000);
    push_seq(b + 18, b + 60, b + 48, 5'b00010);
    fork
      begin
        wait_to(b + 29);
        bus.i_button_n = 1'b1;
      end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        wait_to(e.cyc);
        n_chk++;
        if ({bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause} !== {e.rst, e.rdy, e.rdy, e.cause}) begin
          n_fail++;
          $display("FAIL button_hold cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e.cyc,
                   bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause, e.rst, e.rdy, e.rdy, e.cause);
        end
      end
    join
  endtask

  task automatic test_lock_mid_release();
    exp_t e;
    int   p, l;
    p = cyc + 2;
    l = p + 20;
    wait_to(p - 1);
    bus.i_req = 2'b01;
    push_seq(p, p + 9, p + 1, 5'b01000);
    push_seq(p + 10, l + 25, l + 10, 5'b00100);
    fork
      begin
        wait_to(p);
        bus.i_req = '0;
        wait_to(p + 6);
        bus.i_pll_locked = 1'b0;
        wait_to(l - 1);
        bus.i_pll_locked = 1'b1;
      end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        wait_to(e.cyc);
        n_chk++;
        if ({bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause} !== {e.rst, e.rdy, e.rdy, e.cause}) begin
          n_fail++;
          $display("FAIL lock_mid_release cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e.cyc,
                   bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause, e.rst, e.rdy, e.rdy, e.cause);
        end
      end
    join
  endtask

  task automatic test_por_mid_run();
    exp_t e;
    int   r;
    wait_to(cyc + 2);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause} !== {3'b111, 1'b0, 1'b0, 5'b00001}) begin
      n_fail++;
      $display("FAIL por_async: got rst=%b rdy=%b led=%b cause=%b, want 111/0/0/00001",
               bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause);
    end
    @(negedge clk);
    @(negedge clk);
    r = cyc;
    rst_n = 1'b1;
    push_seq(r + 1, r + 22, r + 11, 5'b00001);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_to(e.cyc);
      n_chk++;
      if ({bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause} !== {e.rst, e.rdy, e.rdy, e.cause}) begin
        n_fail++;
        $display("FAIL por_restart cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e.cyc,
                 bus.o_rst, bus.o_ready, bus.o_led, bus.o_cause, e.rst, e.rdy, e.rdy, e.cause);
      end
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.i_pll_locked = 1'b1;
    bus.i_button_n   = 1'b1;
    bus.i_req        = '0;
    bus.i_req_en     = '1;
    test_reset();
    test_req_pulse("req1_pulse", 2'b10, 2'b11, 1'b1, 5'b10000);
    test_req_pulse("req1_masked", 2'b10, 2'b01, 1'b0, 5'b10000);
    test_button_bounce();
    test_button_hold();
    test_lock_mid_release();
    test_req_pulse("req_both", 2'b11, 2'b11, 1'b1, 5'b01000);
    test_por_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
